// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM states,
// oversample geometry, vote sample positions and a 3-input majority helper.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } rx_state_t;

  localparam int UART_DIV_DEFAULT = 651;
  localparam int UART_OVS         = 16;
  localparam int SAMPLE_A         = 7;
  localparam int SAMPLE_B         = 8;
  localparam int SAMPLE_C         = 9;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing one oversample tick every DIV cycles;
// restart realigns the phase to the detected start edge.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic sysclk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (restart || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST) && !restart;

endmodule

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote per bit,
// a one-entry holding register with overrun detection and break handling.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int DIV = UART_DIV_DEFAULT,
  parameter int OVS = UART_OVS
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ack,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam int SW = (OVS > 1) ? $clog2(OVS) : 1;

  rx_state_t     state, state_next;
  logic          rx_meta, rx_s;
  logic          tick, start_det;
  logic [SW-1:0] sample_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [1:0]    votes;
  logic          at_a, at_b, at_c, at_end, bit_val;
  logic          deliver, frame_bad;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign start_det = (state == S_IDLE) && !rx_s;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .sysclk  (sysclk),
    .reset   (reset),
    .restart (start_det),
    .tick    (tick)
  );

  assign at_a    = tick && (sample_cnt == SW'(SAMPLE_A));
  assign at_b    = tick && (sample_cnt == SW'(SAMPLE_B));
  assign at_c    = tick && (sample_cnt == SW'(SAMPLE_C));
  assign at_end  = tick && (sample_cnt == SW'(OVS - 1));
  // The third vote is the live sample, so the decision lands on the tick-9 cycle.
  assign bit_val = majority3(votes[0], votes[1], rx_s);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    deliver    = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      S_IDLE:  if (!rx_s) state_next = S_START;
      S_START: begin
        if (at_c && bit_val) state_next = S_IDLE;
        else if (at_end)     state_next = S_DATA;
      end
      S_DATA:  if (at_end && bit_cnt == 3'd7) state_next = S_STOP;
      S_STOP: begin
        if (at_c) begin
          if (bit_val) begin
            deliver    = 1'b1;
            state_next = S_IDLE;
          end else begin
            frame_bad  = 1'b1;
            state_next = S_BREAK;
          end
        end
      end
      S_BREAK: if (rx_s) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      votes      <= '0;
    end else begin
      if (start_det) begin
        sample_cnt <= '0;
        bit_cnt    <= '0;
      end else begin
        if (tick) sample_cnt <= at_end ? '0 : sample_cnt + 1'b1;
        if (state == S_DATA && at_end) bit_cnt <= bit_cnt + 1'b1;
      end
      if (at_a) votes[0] <= rx_s;
      if (at_b) votes[1] <= rx_s;
      if (state == S_DATA && at_c) shift <= {bit_val, shift[7:1]};
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_bad;
      if (deliver && (!rx_valid || rx_ack)) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
      // A drop outranks a simultaneous clear.
      if (deliver && rx_valid && !rx_ack) overrun <= 1'b1;
      else if (clr_err)                   overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench: reset, latency, glitch, directed frame table,
// ack-on-delivery, mid-frame reset and randomized frames against a model.
module tb_uart_rx_oversample;

  localparam int DIV = 4;
  localparam int OVS = 16;
  localparam int BIT = DIV * OVS;
  // Start edge -> 2 sync flops -> detect, then the stop-bit tick-9 vote, then the load.
  localparam int LAT = 2 + 9 * BIT + 10 * DIV + 1;

  logic       sysclk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ferr_cnt = 0;

  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ovr = 1'b0;
  int         m_ferr = 0;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         stop_len;
    logic       ack_before;
    logic       clr_before;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ovr;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[8];

  uart_rx_oversample #(.DIV(DIV), .OVS(OVS)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .rx        (rx),
    .rx_ack    (rx_ack),
    .clr_err   (clr_err),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    cyc <= cyc + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // Called at a negedge; drives one 8N1 frame, optionally stopping after abort_at cycles.
  task automatic drive_frame(input logic [7:0] b, input logic stop, input int stop_len,
                             input int abort_at);
    logic [9:0] bits;
    int t;
    bits = {stop, b, 1'b0};
    t = 0;
    for (int i = 0; i < 10; i++) begin
      int len;
      len = (i == 9) ? stop_len : BIT;
      rx = bits[i];
      for (int c = 0; c < len; c++) begin
        if (abort_at > 0 && t == abort_at) return;
        @(negedge sysclk);
        t++;
      end
    end
    rx = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      if (!m_valid) begin
        m_data  = b;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      m_ferr++;
    end
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    @(negedge sysclk);
    rx_ack = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr_err = 1'b1;
    @(negedge sysclk);
    clr_err = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, " rx_data"}, rx_data, m_data);
    check({tag, " rx_valid"}, rx_valid, m_valid);
    check({tag, " overrun"}, overrun, m_ovr);
    check({tag, " frame_err pulses"}, ferr_cnt, m_ferr);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " rx_data"}, rx_data, 8'h00);
    check({tag, " rx_valid"}, rx_valid, 1'b0);
    check({tag, " frame_err"}, frame_err, 1'b0);
    check({tag, " overrun"}, overrun, 1'b0);
  endtask

  initial begin
    int t0, lat, f0;
    logic found, dropped;

    vecs[0] = '{8'hA3, 1'b0, 200, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1};
    vecs[1] = '{8'h3C, 1'b1, BIT, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 0};
    vecs[2] = '{8'h11, 1'b1, BIT, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 0};
    vecs[3] = '{8'h22, 1'b1, BIT, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 0};
    vecs[4] = '{8'h9A, 1'b1, BIT, 1'b1, 1'b1, 8'h9A, 1'b1, 1'b0, 0};
    vecs[5] = '{8'h5A, 1'b0, 100, 1'b0, 1'b0, 8'h9A, 1'b1, 1'b0, 1};
    vecs[6] = '{8'hE7, 1'b1, BIT, 1'b0, 1'b0, 8'h9A, 1'b1, 1'b1, 0};
    vecs[7] = '{8'h0F, 1'b1, BIT, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 0};

    wait_cycles(5);
    check_reset_values("reset");
    reset = 1'b1;
    wait_cycles(10);

    // Latency of the first frame, measured from the driven start edge.
    t0 = cyc;
    lat = -1;
    found = 1'b0;
    fork
      drive_frame(8'h55, 1'b1, BIT, 0);
      begin
        for (int n = 0; n < 2000 && !found; n++) begin
          @(negedge sysclk);
          if (rx_valid) begin
            found = 1'b1;
            lat = cyc - t0;
          end
        end
      end
    join
    check("latency 0x55", lat, LAT);
    model_frame(8'h55, 1'b1);
    wait_cycles(50);
    compare_model("frame 0x55");
    $display("frame 55 latency %0d data %02h valid %0d", lat, rx_data, rx_valid);

    do_ack();
    rx = 1'b0;
    wait_cycles(24);
    rx = 1'b1;
    wait_cycles(3 * BIT);
    compare_model("glitch");
    $display("glitch 24 cycles valid %0d ferr %0d", rx_valid, ferr_cnt);

    for (int i = 0; i < 8; i++) begin
      f0 = ferr_cnt;
      if (vecs[i].ack_before) do_ack();
      if (vecs[i].clr_before) do_clr();
      drive_frame(vecs[i].b, vecs[i].stop, vecs[i].stop_len, 0);
      model_frame(vecs[i].b, vecs[i].stop);
      wait_cycles(100);
      check($sformatf("vec%0d rx_data", i), rx_data, vecs[i].exp_data);
      check($sformatf("vec%0d rx_valid", i), rx_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d overrun", i), overrun, vecs[i].exp_ovr);
      check($sformatf("vec%0d frame_err", i), ferr_cnt - f0, vecs[i].exp_ferr);
      $display("vec%0d byte %02h stop %0d -> data %02h valid %0d ovr %0d", i, vecs[i].b,
               vecs[i].stop, rx_data, rx_valid, overrun);
      if (i == 3) begin
        do_clr();
        check("clr_err overrun", overrun, 1'b0);
        check("clr_err rx_data", rx_data, 8'h11);
        $display("clr_err -> ovr %0d data %02h", overrun, rx_data);
      end
    end

    // Ack lands exactly in the cycle the next byte is delivered.
    do_ack();
    drive_frame(8'h66, 1'b1, BIT, 0);
    model_frame(8'h66, 1'b1);
    wait_cycles(100);
    compare_model("frame 0x66");
    dropped = 1'b0;
    fork
      drive_frame(8'h77, 1'b1, BIT, 0);
      begin
        wait_cycles(LAT - 1);
        rx_ack = 1'b1;
        @(negedge sysclk);
        rx_ack = 1'b0;
      end
      begin
        for (int n = 0; n < LAT + 10; n++) begin
          @(negedge sysclk);
          if (!rx_valid) dropped = 1'b1;
        end
      end
    join
    m_data = 8'h77;
    wait_cycles(50);
    compare_model("ack on delivery");
    check("ack on delivery valid held", dropped, 1'b0);
    $display("ack-on-delivery 77 -> data %02h valid %0d ovr %0d", rx_data, rx_valid, overrun);

    drive_frame(8'h44, 1'b1, BIT, 0);
    model_frame(8'h44, 1'b1);
    wait_cycles(100);
    compare_model("pre-reset overrun");

    // Reset in the middle of data bit 4 of 0x9C.
    drive_frame(8'h9C, 1'b1, BIT, 5 * BIT + 32);
    reset = 1'b0;
    wait_cycles(3);
    check_reset_values("mid-frame reset");
    rx = 1'b1;
    reset = 1'b1;
    m_data = 8'h00;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    wait_cycles(12 * BIT);
    compare_model("after reset");
    drive_frame(8'h01, 1'b1, BIT, 0);
    model_frame(8'h01, 1'b1);
    wait_cycles(100);
    compare_model("frame 0x01");
    $display("after reset frame 01 -> data %02h valid %0d", rx_data, rx_valid);

    for (int i = 0; i < 20; i++) begin
      logic [7:0] b;
      logic stop;
      int slen;
      b = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      slen = stop ? BIT : $urandom_range(BIT, 200);
      if ($urandom_range(0, 1) == 1) do_ack();
      if ($urandom_range(0, 3) == 0) do_clr();
      drive_frame(b, stop, slen, 0);
      model_frame(b, stop);
      wait_cycles($urandom_range(80, 200));
      compare_model($sformatf("rand%0d", i));
      $display("rand%0d byte %02h stop %0d -> data %02h valid %0d ovr %0d", i, b, stop,
               rx_data, rx_valid, overrun);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
